kugelblitz_extract: RTL and testbench

KUGELBLITZ_EXTRACT -- requirements
Module: kugelblitz_extract

---
 rtl/kugelblitz_extract.sv | 230 +++++++++++++++++++++++
 tb/tb_kugelblitz_extract.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kugelblitz_extract.sv
// Passive AXI-Stream byte extractor: snoops frames, captures one byte per frame at a
// programmable offset into a small FIFO, and exposes control/status/data over AXI-Lite.
module kugelblitz_extract #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tready,
    input  logic                         s_axis_tlast,

    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                   s_axil_awprot,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_CTRL   = AXIL_ADDR_WIDTH'(8'h00);
    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_OFFSET = AXIL_ADDR_WIDTH'(8'h04);
    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_STATUS = AXIL_ADDR_WIDTH'(8'h08);
    localparam logic [AXIL_ADDR_WIDTH-1:0] ADDR_DATA   = AXIL_ADDR_WIDTH'(8'h0C);

    logic              enable;
    logic [13:0]       offset;
    logic              flush_pend;

    logic [8:0]        beat_cnt;
    logic              frame_captured;
    logic              cap_valid;
    logic [7:0]        cap_byte;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fill_cnt;
    logic [15:0]       drop_cnt;

    logic              aw_rdy;
    logic              ar_rdy;
    logic              bvalid;
    logic              rvalid;
    logic [AXIL_DATA_WIDTH-1:0] rdata;

    logic              xfer;
    logic [5:0]        lane;
    logic              capture;
    logic              wr_hs;
    logic              rd_hs;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [31:0]       rd_word;
    logic              unused_ok;

    assign xfer    = s_axis_tvalid && s_axis_tready;
    assign lane    = offset[5:0];
    // beat_cnt parked at 256 can never match an 8-bit beat index, so saturation blocks capture
    assign capture = xfer && enable && !frame_captured
                     && (beat_cnt == {1'b0, offset[13:6]})
                     && s_axis_tkeep[lane];

    assign wr_hs = aw_rdy && s_axil_awvalid && s_axil_wvalid;
    assign rd_hs = ar_rdy && s_axil_arvalid;

    assign fifo_full  = (fill_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fill_cnt == '0);
    assign pop        = rd_hs && (s_axil_araddr == ADDR_DATA) && !fifo_empty && !flush_pend;
    assign push_ok    = cap_valid && !flush_pend && (!fifo_full || pop);
    assign drop       = cap_valid && !flush_pend && !push_ok;

    assign s_axil_awready = aw_rdy;
    assign s_axil_wready  = aw_rdy;
    assign s_axil_bvalid  = bvalid;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_arready = ar_rdy;
    assign s_axil_rvalid  = rvalid;
    assign s_axil_rresp   = 2'b00;
    assign s_axil_rdata   = rdata;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt       <= '0;
            frame_captured <= 1'b0;
            cap_valid      <= 1'b0;
            cap_byte       <= '0;
        end else begin
            cap_valid <= capture;
            if (capture) begin
                cap_byte <= s_axis_tdata[{lane, 3'b000} +: 8];
            end
            if (xfer) begin
                if (s_axis_tlast) begin
                    beat_cnt       <= '0;
                    frame_captured <= 1'b0;
                end else begin
                    if (beat_cnt != 9'd256) begin
                        beat_cnt <= beat_cnt + 9'd1;
                    end
                    if (capture) begin
                        frame_captured <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_rdy     <= 1'b0;
            bvalid     <= 1'b0;
            enable     <= 1'b0;
            offset     <= '0;
            flush_pend <= 1'b0;
        end else begin
            aw_rdy     <= s_axil_awvalid && s_axil_wvalid && !bvalid && !aw_rdy;
            flush_pend <= 1'b0;
            if (wr_hs) begin
                bvalid <= 1'b1;
                if (s_axil_awaddr == ADDR_CTRL) begin
                    enable     <= s_axil_wdata[0];
                    flush_pend <= s_axil_wdata[1];
                end else if (s_axil_awaddr == ADDR_OFFSET) begin
                    offset <= s_axil_wdata[13:0];
                end
            end else if (s_axil_bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (s_axil_araddr == ADDR_CTRL) begin
            rd_word[0] = enable;
        end else if (s_axil_araddr == ADDR_OFFSET) begin
            rd_word[13:0] = offset;
        end else if (s_axil_araddr == ADDR_STATUS) begin
            rd_word[4:0]   = 5'(fill_cnt);
            rd_word[8]     = fifo_empty;
            rd_word[9]     = fifo_full;
            rd_word[31:16] = drop_cnt;
        end else if (s_axil_araddr == ADDR_DATA) begin
            if (pop) begin
                rd_word = {1'b1, 23'b0, mem[rd_ptr]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_rdy <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            ar_rdy <= s_axil_arvalid && !rvalid && !ar_rdy;
            if (rd_hs) begin
                rvalid <= 1'b1;
                rdata  <= AXIL_DATA_WIDTH'(rd_word);
            end else if (s_axil_rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // A flush wins over a same-cycle push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush_pend) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                fill_cnt <= fill_cnt + CNT_W'(1);
            end else if (pop && !push_ok) begin
                fill_cnt <= fill_cnt - CNT_W'(1);
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= cap_byte;
        end
    end

endmodule

// File: tb/tb_kugelblitz_extract.sv
// Bench for kugelblitz_extract: directed scenarios plus randomized frames checked
// against a frame-level byte-offset model with a queue-based FIFO.
module tb_kugelblitz_extract;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tdata = '0;
    logic [KW-1:0] tkeep = '0;
    logic          tvalid = 1'b0;
    logic          tready = 1'b1;
    logic          tlast = 1'b0;
    logic [7:0]    awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [7:0]    araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] fd [8];
    logic [KW-1:0] fk [8];
    bit            stall_en = 1'b0;

    logic [7:0]    q [$];
    int            m_drop = 0;

    kugelblitz_extract dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (tdata),
        .s_axis_tkeep   (tkeep),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tlast   (tlast),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axil_write(input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("aw_w_ready", 32'({awready, wready}), 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
        @(posedge clk); #1;
        check("bvalid_hold", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axil_read(input logic [7:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid", 32'(rvalid), 32'd1);
        check("rresp", 32'(rresp), 32'd0);
        d = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic send_frame(input int nb);
        for (int b = 0; b < nb; b++) begin
            tdata = fd[b]; tkeep = fk[b]; tlast = (b == nb - 1); tvalid = 1'b1;
            do begin
                tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                @(posedge clk); #1;
            end while (!tready);
        end
        tvalid = 1'b0; tlast = 1'b0; tready = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else if (m_drop < 65535) m_drop++;
    endtask

    // Byte number off in the frame lives in beat off/64, lane off%64
    task automatic frame_model(input int nb, input int off, input bit en);
        int beat = off / 64;
        int lane = off % 64;
        if (en && beat < nb && fk[beat][lane]) model_push(fd[beat][lane*8 +: 8]);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s = '0;
        s[4:0]   = 5'(q.size());
        s[8]     = (q.size() == 0);
        s[9]     = (q.size() == DEPTH);
        s[31:16] = 16'(m_drop);
        return s;
    endfunction

    task automatic read_data_check(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        axil_read(8'h0C, d);
        if (q.size() > 0) e = {1'b1, 23'b0, q.pop_front()};
        else e = 32'h0;
        check(tag, d, e);
    endtask

    task automatic read_status_check(input string tag);
        logic [31:0] d;
        axil_read(8'h08, d);
        check(tag, d, exp_status());
    endtask

    task automatic single_byte_frames(input int count, input int base);
        for (int i = 0; i < count; i++) begin
            fd[0] = rand_beat();
            fd[0][7:0] = 8'(base + i);
            fk[0] = '1;
            send_frame(1);
            frame_model(1, 0, 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        int          nb;
        int          m_off;
        bit          m_en;

        #1;
        check("rst_awready", 32'({awready, wready, arready}), 32'd0);
        check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        read_status_check("init_status");
        check("init_status_const", exp_status(), 32'h0000_0100);

        // Offset 0x45 -> beat 1, lane 5
        axil_write(8'h04, 32'h45);
        axil_write(8'h00, 32'h1);
        for (int b = 0; b < 3; b++) begin fd[b] = rand_beat(); fk[b] = '1; end
        fd[1][5*8 +: 8] = 8'h5A;
        send_frame(3);
        frame_model(3, 'h45, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        axil_read(8'h08, d);
        check("cap_fill", 32'(d[4:0]), 32'd1);
        axil_read(8'h0C, d);
        check("cap_data", d, 32'h8000_005A);
        void'(q.pop_front());
        axil_read(8'h08, d);
        check("cap_empty", 32'(d[8]), 32'd1);

        // Offset 0x7F lands in a lane with tkeep=0 on the last beat
        axil_write(8'h04, 32'h7F);
        for (int b = 0; b < 2; b++) begin fd[b] = rand_beat(); fk[b] = '1; end
        fk[1] = 64'h0000_0000_FFFF_FFFF;
        send_frame(2);
        frame_model(2, 'h7F, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        axil_read(8'h0C, d);
        check("partial_miss", d, 32'h0);

        // Overflow: 18 frames, no reads
        axil_write(8'h04, 32'h0);
        single_byte_frames(18, 0);
        read_status_check("full_status");
        axil_read(8'h08, d);
        check("full_status_const", d, 32'h0002_0210);

        // DATA read accepted in the same cycle the capture pushes
        fd[0] = rand_beat(); fd[0][7:0] = 8'hAA; fk[0] = '1;
        araddr = 8'h0C; arvalid = 1'b1;
        tdata = fd[0]; tkeep = fk[0]; tlast = 1'b1; tvalid = 1'b1; tready = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
        check("conc_arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("conc_rvalid", 32'(rvalid), 32'd1);
        check("conc_rdata", rdata, {1'b1, 23'b0, q.pop_front()});
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        model_push(8'hAA);
        read_status_check("conc_status");
        axil_read(8'h08, d);
        check("conc_status_const", d, 32'h0002_0210);
        for (int i = 1; i < DEPTH; i++) begin
            axil_read(8'h0C, d);
            check("drain_order", d, 32'h8000_0000 | 32'(i));
            void'(q.pop_front());
        end
        read_data_check("drain_last");
        read_data_check("drain_empty");

        // Flush with 5 entries and drop=3
        single_byte_frames(17, 'h20);
        for (int i = 0; i < 11; i++) read_data_check("pre_flush_read");
        read_status_check("pre_flush_status");
        axil_write(8'h00, 32'h3);
        q.delete(); m_drop = 0;
        axil_read(8'h08, d);
        check("flush_status", d, 32'h0000_0100);
        axil_read(8'h00, d);
        check("ctrl_after_flush", d, 32'h1);

        // Unmapped read and RO write
        axil_read(8'h10, d);
        check("unmapped_read", d, 32'h0);
        axil_write(8'h08, 32'hFFFF_FFFF);
        axil_write(8'h0C, 32'hFFFF_FFFF);
        read_status_check("ro_write_status");

        // Async reset mid-frame and mid-read
        axil_write(8'h04, 32'h42);
        fd[0] = rand_beat(); fk[0] = '1;
        tdata = fd[0]; tkeep = fk[0]; tlast = 1'b0; tvalid = 1'b1; tready = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        @(posedge clk); #1;
        tvalid = 1'b0; arvalid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'({awready, wready, arready}), 32'd0);
        check("arst_valid", 32'({bvalid, rvalid}), 32'd0);
        check("arst_resp", 32'({bresp, rresp}), 32'd0);
        check("arst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        check("arst_hold", 32'({arready, rvalid, bvalid}), 32'd0);
        rst = 1'b0;
        q.delete(); m_drop = 0;
        @(posedge clk); #1;
        read_status_check("post_rst_status");
        axil_read(8'h00, d);
        check("post_rst_ctrl", d, 32'h0);
        axil_read(8'h04, d);
        check("post_rst_offset", d, 32'h0);
        axil_write(8'h04, 32'h42);
        axil_write(8'h00, 32'h1);
        for (int b = 0; b < 2; b++) begin fd[b] = rand_beat(); fk[b] = '1; end
        fd[1][2*8 +: 8] = 8'hC3;
        send_frame(2);
        frame_model(2, 'h42, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        axil_read(8'h0C, d);
        check("post_rst_beat0", d, 32'h8000_00C3);
        void'(q.pop_front());

        // Randomized frames against the model
        m_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                m_en = 1'($urandom_range(0, 1));
                axil_write(8'h00, {31'b0, m_en});
            end
            m_off = int'($urandom_range(0, 4)) * 64 + int'($urandom_range(0, 63));
            axil_write(8'h04, 32'(m_off));
            nb = int'($urandom_range(1, 4));
            for (int b = 0; b < nb; b++) begin
                fd[b] = rand_beat();
                fk[b] = {$urandom, $urandom} | {$urandom, $urandom};
            end
            stall_en = 1'b1;
            send_frame(nb);
            stall_en = 1'b0;
            frame_model(nb, m_off, m_en);
            repeat (2) @(posedge clk);
            #1;
            case ($urandom_range(0, 2))
                0: read_data_check("rand_data");
                1: read_status_check("rand_status");
                default: ;
            endcase
        end
        read_status_check("rand_final_status");
        while (q.size() > 0) read_data_check("rand_drain");
        read_data_check("rand_drain_empty");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

endmodule
